dma_priority_resolver: RTL and testbench

- Channel priority and request/acknowledge stage of the 4-channel DMA controller.
- Resolves pending DMA requests into one bus-hold request (HRQ) and drives the DMA acknowledge (DACK) for the granted channel.
- Feeds the timing-control state machine and consumes its end-of-service pulse.
- Owns the priority-order register (fixed or rotating priority).

---
 rtl/dma_pkg.sv | 36 +++
 rtl/dma_priority_resolver_if.sv | 30 +++
 rtl/dma_priority_encoder.sv | 23 ++
 rtl/dma_priority_resolver.sv | 144 ++++++++++++++
 tb/tb_dma_priority_resolver.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel priority / request stage.
package dma_pkg;

    localparam int         CHANNELS      = 4;
    localparam logic [7:0] DEFAULT_ORDER = 8'b11_10_01_00;

    // One-hot state encoding for the request/grant FSM.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_REQ   = 3'b010,
        ST_GRANT = 3'b100
    } state_t;

    typedef logic [1:0] chan_id_t;

    // Element [0] is the highest-priority channel; packed so it maps directly onto the 8-bit order bus.
    typedef chan_id_t [CHANNELS-1:0] prio_order_t;

    // One-hot decode of a channel id.
    function automatic logic [CHANNELS-1:0] chan_onehot(input chan_id_t id);
        logic [CHANNELS-1:0] one;
        one = {{(CHANNELS-1){1'b0}}, 1'b1};
        return one << id;
    endfunction

    // Order after servicing channel k: k+1 becomes highest, k drops to lowest.
    function automatic prio_order_t rotate_after(input chan_id_t k);
        prio_order_t r;
        r[0] = k + 2'd1;
        r[1] = k + 2'd2;
        r[2] = k + 2'd3;
        r[3] = k;
        return r;
    endfunction

endpackage

// File: rtl/dma_priority_resolver_if.sv
// Bus-side request/hold/acknowledge signals of the DMA priority resolver.
//
// Handshake: the resolver raises HRQ while it holds a candidate channel
// (channelValid=1). The CPU answers with HLDA; once HLDA is sampled high the
// candidate is frozen and DACK goes one-hot on it. The grant lasts until the
// timing control pulses serviceEnd for one cycle, or until HLDA drops (abort).
interface dma_priority_resolver_if;
    import dma_pkg::*;

    logic [CHANNELS-1:0] DREQ;
    logic                HLDA;
    logic                serviceEnd;
    logic                HRQ;
    logic [CHANNELS-1:0] DACK;
    chan_id_t            activeChannel;
    logic                channelValid;

    // Resolver side.
    modport master (
        input  DREQ, HLDA, serviceEnd,
        output HRQ, DACK, activeChannel, channelValid
    );

    // CPU / timing-control / pin side.
    modport slave (
        output DREQ, HLDA, serviceEnd,
        input  HRQ, DACK, activeChannel, channelValid
    );

endinterface

// File: rtl/dma_priority_encoder.sv
// Picks the first pending channel when scanning the priority order from field0 upward.
module dma_priority_encoder
    import dma_pkg::*;
(
    input  logic [CHANNELS-1:0] pending,
    input  prio_order_t         order,
    output chan_id_t            winner,
    output logic                valid
);

    // Scan lowest priority first so the highest-priority hit is the last assignment.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending[order[i]]) begin
                winner = order[i];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_resolver.sv
// Request/acknowledge stage of the 4-channel DMA controller: arbitrates pending
// channels, drives HRQ/DACK and maintains the fixed or rotating priority order.
module dma_priority_resolver
    import dma_pkg::*;
#(
    parameter int         CHANNELS      = dma_pkg::CHANNELS,
    parameter logic [7:0] DEFAULT_ORDER = dma_pkg::DEFAULT_ORDER
) (
    input  logic                     CLK,
    input  logic                     RESET,
    dma_priority_resolver_if.master  bus,
    input  logic [CHANNELS-1:0]      softwareReq,
    input  logic [CHANNELS-1:0]      maskReg,
    input  logic                     controllerDisable,
    input  logic                     rotatePriority,
    input  logic                     dreqSenseLow,
    output logic [CHANNELS-1:0]      swReqClear,
    output logic [7:0]               priorityOrder,
    output state_t                   state_dbg
);

    state_t              state_q, state_d;
    chan_id_t            active_q, active_d;
    logic                hrq_q, hrq_d;
    logic                cv_q, cv_d;
    logic [CHANNELS-1:0] dack_q, dack_d;
    logic [CHANNELS-1:0] swc_q, swc_d;
    prio_order_t         prio_q, prio_d;

    logic [CHANNELS-1:0] pending;
    chan_id_t            winner;
    logic                winner_valid;

    // Masking applies to hardware DREQ only; disable only blocks fresh arbitration from IDLE.
    always_comb begin
        pending = ((bus.DREQ ^ {CHANNELS{dreqSenseLow}}) & ~maskReg) | softwareReq;
        if (controllerDisable && (state_q == ST_IDLE)) begin
            pending = '0;
        end
    end

    dma_priority_encoder u_encoder (
        .pending (pending),
        .order   (prio_q),
        .winner  (winner),
        .valid   (winner_valid)
    );

    // Next-state and next-output logic; all outputs are registered.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        hrq_d    = hrq_q;
        cv_d     = cv_q;
        dack_d   = dack_q;
        swc_d    = '0;
        prio_d   = prio_q;

        case (state_q)
            ST_IDLE: begin
                if (winner_valid) begin
                    state_d  = ST_REQ;
                    active_d = winner;
                    hrq_d    = 1'b1;
                    cv_d     = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.HLDA) begin
                    // Candidate is frozen from here on.
                    state_d = ST_GRANT;
                    dack_d  = chan_onehot(active_q);
                end else if (!winner_valid) begin
                    state_d = ST_IDLE;
                    hrq_d   = 1'b0;
                    cv_d    = 1'b0;
                end else begin
                    active_d = winner;
                end
            end
            ST_GRANT: begin
                // serviceEnd wins over a simultaneous HLDA drop.
                if (bus.serviceEnd) begin
                    state_d = ST_IDLE;
                    hrq_d   = 1'b0;
                    cv_d    = 1'b0;
                    dack_d  = '0;
                    if (softwareReq[active_q]) begin
                        swc_d = chan_onehot(active_q);
                    end
                    if (rotatePriority) begin
                        prio_d = rotate_after(active_q);
                    end
                end else if (!bus.HLDA) begin
                    state_d = ST_IDLE;
                    hrq_d   = 1'b0;
                    cv_d    = 1'b0;
                    dack_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hrq_d   = 1'b0;
                cv_d    = 1'b0;
                dack_d  = '0;
            end
        endcase

        // Fixed mode keeps reloading the default order.
        if (!rotatePriority) begin
            prio_d = prio_order_t'(DEFAULT_ORDER);
        end
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
            hrq_q    <= 1'b0;
            cv_q     <= 1'b0;
            dack_q   <= '0;
            swc_q    <= '0;
            prio_q   <= prio_order_t'(DEFAULT_ORDER);
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            hrq_q    <= hrq_d;
            cv_q     <= cv_d;
            dack_q   <= dack_d;
            swc_q    <= swc_d;
            prio_q   <= prio_d;
        end
    end

    assign bus.HRQ           = hrq_q;
    assign bus.DACK          = dack_q;
    assign bus.activeChannel = active_q;
    assign bus.channelValid  = cv_q;
    assign swReqClear        = swc_q;
    assign priorityOrder     = prio_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for the DMA priority resolver. Each output change is matched
// against an expected {cycle, outputs} entry queued by the stimulus.
module tb_dma_priority_resolver;
    import dma_pkg::*;

    localparam int W = 36;  // 16-bit cycle + 20-bit output snapshot

    localparam logic [7:0] ORD_DEF  = 8'hE4;  // 11_10_01_00
    localparam logic [7:0] ORD_AFT1 = 8'h4E;  // 01_00_11_10
    localparam logic [7:0] ORD_AFT0 = 8'h39;  // 00_11_10_01

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] software_req;
    logic [3:0] mask_reg;
    logic       controller_disable;
    logic       rotate_priority;
    logic       dreq_sense_low;
    logic [3:0] sw_req_clear;
    logic [7:0] priority_order;
    state_t     state_dbg;

    logic [15:0]  cyc = '0;
    logic [W-1:0] exp_q[$];
    logic [19:0]  prev_snap = 'x;
    int           checks = 0;
    int           errors = 0;

    dma_priority_resolver_if bus();

    dma_priority_resolver dut (
        .CLK               (clk),
        .RESET             (rst_n),
        .bus               (bus),
        .softwareReq       (software_req),
        .maskReg           (mask_reg),
        .controllerDisable (controller_disable),
        .rotatePriority    (rotate_priority),
        .dreqSenseLow      (dreq_sense_low),
        .swReqClear        (sw_req_clear),
        .priorityOrder     (priority_order),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 16'd1;

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [19:0] pack_snap(input logic hrq, input logic [3:0] dack,
                                              input logic [1:0] ac, input logic cv,
                                              input logic [3:0] swc, input logic [7:0] prio);
        return {hrq, dack, ac, cv, swc, prio};
    endfunction

    task automatic push_exp(input int dly, input logic hrq, input logic [3:0] dack,
                            input logic [1:0] ac, input logic cv,
                            input logic [3:0] swc, input logic [7:0] prio);
        exp_q.push_back({cyc + 16'(dly), pack_snap(hrq, dack, ac, cv, swc, prio)});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [19:0]  cur;
        logic [W-1:0] got;
        logic [W-1:0] want;
        cur = pack_snap(bus.HRQ, bus.DACK, bus.activeChannel, bus.channelValid,
                        sw_req_clear, priority_order);
        if (cur !== prev_snap) begin
            prev_snap = cur;
            got = {cyc, cur};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got cyc=%0d snap=%h, no entry queued",
                         got[35:20], got[19:0]);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL out_change: got cyc=%0d snap=%h want cyc=%0d snap=%h",
                             got[35:20], got[19:0], want[35:20], want[19:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    // push_exp args: delay, HRQ, DACK, activeChannel, channelValid, swReqClear, priorityOrder
    initial begin
        bus.DREQ           = 4'b0000;
        bus.HLDA           = 1'b0;
        bus.serviceEnd     = 1'b0;
        software_req       = 4'b0000;
        mask_reg           = 4'b0000;
        controller_disable = 1'b0;
        rotate_priority    = 1'b0;
        dreq_sense_low     = 1'b0;
        push_exp(1, 0, 4'b0000, 2'd0, 0, 4'b0000, ORD_DEF);  // reset state
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // 1: fixed mode, DREQ=0110 -> ch1; HLDA two cycles after HRQ
        bus.DREQ = 4'b0110;
        push_exp(1, 1, 4'b0000, 2'd1, 1, 4'b0000, ORD_DEF);
        tick(3);
        bus.HLDA = 1'b1;
        push_exp(1, 1, 4'b0010, 2'd1, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.serviceEnd = 1'b1;                                // no rotation in fixed mode
        push_exp(1, 0, 4'b0000, 2'd1, 0, 4'b0000, ORD_DEF);
        tick(1);
        bus.serviceEnd = 1'b0;
        bus.HLDA = 1'b0;                                      // earliest re-request
        push_exp(1, 1, 4'b0000, 2'd1, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.DREQ = 4'b0000;                                   // request withdrawn in REQ
        push_exp(1, 0, 4'b0000, 2'd1, 0, 4'b0000, ORD_DEF);
        tick(1);

        // 2: rotating mode, service ch1, then ch0 wins with 0011 pending
        rotate_priority = 1'b1;
        bus.DREQ = 4'b0010;
        push_exp(1, 1, 4'b0000, 2'd1, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.HLDA = 1'b1;
        push_exp(1, 1, 4'b0010, 2'd1, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.serviceEnd = 1'b1;
        bus.DREQ = 4'b0011;
        push_exp(1, 0, 4'b0000, 2'd1, 0, 4'b0000, ORD_AFT1);
        tick(1);
        bus.serviceEnd = 1'b0;
        bus.HLDA = 1'b0;
        push_exp(1, 1, 4'b0000, 2'd0, 1, 4'b0000, ORD_AFT1);
        tick(1);
        bus.HLDA = 1'b1;
        push_exp(1, 1, 4'b0001, 2'd0, 1, 4'b0000, ORD_AFT1);
        tick(1);
        bus.serviceEnd = 1'b1;
        bus.DREQ = 4'b0000;
        push_exp(1, 0, 4'b0000, 2'd0, 0, 4'b0000, ORD_AFT0);
        tick(1);
        bus.serviceEnd = 1'b0;
        bus.HLDA = 1'b0;
        rotate_priority = 1'b0;                               // fixed mode reloads default
        push_exp(1, 0, 4'b0000, 2'd0, 0, 4'b0000, ORD_DEF);
        tick(1);

        // 3: candidate ch3 replaced by ch0 before HLDA; disable blocks only IDLE
        bus.DREQ = 4'b1000;
        push_exp(1, 1, 4'b0000, 2'd3, 1, 4'b0000, ORD_DEF);
        tick(2);
        bus.DREQ = 4'b1001;
        push_exp(1, 1, 4'b0000, 2'd0, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.HLDA = 1'b1;
        push_exp(1, 1, 4'b0001, 2'd0, 1, 4'b0000, ORD_DEF);
        tick(1);
        controller_disable = 1'b1;                            // must not abort the grant
        tick(1);
        bus.serviceEnd = 1'b1;
        bus.DREQ = 4'b0000;
        push_exp(1, 0, 4'b0000, 2'd0, 0, 4'b0000, ORD_DEF);
        tick(1);
        bus.serviceEnd = 1'b0;
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b1000;                                   // held off by disable
        tick(2);
        controller_disable = 1'b0;
        push_exp(1, 1, 4'b0000, 2'd3, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.DREQ = 4'b0000;
        push_exp(1, 0, 4'b0000, 2'd3, 0, 4'b0000, ORD_DEF);
        tick(1);

        // 4: all DREQ masked, software request ch2, clear pulse after service
        mask_reg = 4'b1111;
        bus.DREQ = 4'b1111;
        software_req = 4'b0100;
        push_exp(1, 1, 4'b0000, 2'd2, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.HLDA = 1'b1;
        push_exp(1, 1, 4'b0100, 2'd2, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.serviceEnd = 1'b1;
        push_exp(1, 0, 4'b0000, 2'd2, 0, 4'b0100, ORD_DEF);
        tick(1);
        bus.serviceEnd = 1'b0;
        bus.HLDA = 1'b0;
        software_req = 4'b0000;
        push_exp(1, 0, 4'b0000, 2'd2, 0, 4'b0000, ORD_DEF);
        tick(1);

        // 5: active-low DREQ, abort by HLDA drop (rotate mode, no rotation)
        mask_reg = 4'b0000;
        dreq_sense_low = 1'b1;
        rotate_priority = 1'b1;
        bus.DREQ = 4'b1110;
        push_exp(1, 1, 4'b0000, 2'd0, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.HLDA = 1'b1;
        push_exp(1, 1, 4'b0001, 2'd0, 1, 4'b0000, ORD_DEF);
        tick(2);
        bus.HLDA = 1'b0;
        push_exp(1, 0, 4'b0000, 2'd0, 0, 4'b0000, ORD_DEF);
        tick(1);
        // serviceEnd together with HLDA falling counts as a normal end
        bus.DREQ = 4'b1101;
        push_exp(1, 1, 4'b0000, 2'd1, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.HLDA = 1'b1;
        software_req = 4'b0010;
        push_exp(1, 1, 4'b0010, 2'd1, 1, 4'b0000, ORD_DEF);
        tick(1);
        bus.serviceEnd = 1'b1;
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b1111;
        push_exp(1, 0, 4'b0000, 2'd1, 0, 4'b0010, ORD_AFT1);
        tick(1);
        bus.serviceEnd = 1'b0;
        software_req = 4'b0000;
        push_exp(1, 0, 4'b0000, 2'd1, 0, 4'b0000, ORD_AFT1);
        tick(1);

        // 6: asynchronous reset in the middle of a grant
        bus.DREQ = 4'b1110;
        push_exp(1, 1, 4'b0000, 2'd0, 1, 4'b0000, ORD_AFT1);
        tick(1);
        bus.HLDA = 1'b1;
        push_exp(1, 1, 4'b0001, 2'd0, 1, 4'b0000, ORD_AFT1);
        tick(2);
        push_exp(0, 0, 4'b0000, 2'd0, 0, 4'b0000, ORD_DEF);
        rst_n = 1'b0;
        #1;
        check_val("async_reset_hrq",   {7'd0, bus.HRQ},    8'd0);
        check_val("async_reset_dack",  {4'd0, bus.DACK},   8'd0);
        check_val("async_reset_order", priority_order,     ORD_DEF);
        check_val("async_reset_state", {5'd0, state_dbg},  {5'd0, ST_IDLE});
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b1111;
        tick(2);
        rst_n = 1'b1;
        tick(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d unmatched entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
